prim_rom_reader: RTL and testbench
==================================

// Module: prim_rom_reader
// PURPOSE
//  Read-side initiator for the single-port synchronous ROM macro (addr/cs in; dout/dvalid out, 1-cycle latency).
//  On start, fetches len consecutive words from base_addr and emits them on a valid/ready stream with a last flag.
//  Issue is credit-throttled, so downstream backpressure never drops ROM data. Sits between boot ROM and loader/DMA.
// PARAMETERS
//  Width     32                 ROM word width; stream data width
//  Depth     2048               ROM depth in words
//  Aw        $clog2(Depth)      ROM address width
//  FifoDepth 2                  output buffer entries (>=2; 2 sustains 1 word/cycle)
// PORTS
//  clk_i         in   1       single clock, rising edge
//  rst_i         in   1       synchronous, active-high reset
//  start_i       in   1       begin a burst; sampled only when busy_o=0
//  base_addr_i   in   Aw      first word address, captured with start_i
//  len_i         in   Aw+1    word count 0..Depth, captured with start_i
//  busy_o        out  1       burst in progress (issue or drain)
//  done_o        out  1       1-cycle pulse: last word accepted downstream (or len=0)
//  rom_addr_o    out  Aw      to ROM addr_i
//  rom_cs_o      out  1       to ROM cs_i
//  rom_dout_i    in   Width   from ROM dout_o
//  rom_dvalid_i  in   1       from ROM dvalid_o
//  data_o        out  Width   stream data
//  data_valid_o  out  1       stream valid
//  data_ready_i  in   1       stream ready
//  data_last_o   out  1       qualifies final word of burst
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state IDLE; busy_o, done_o, rom_cs_o, data_valid_o, data_last_o=0; rom_addr_o=0;
//    FIFO empty; outstanding=0; remaining counters=0. Reset mid-burst aborts; no done_o pulse.
//  FSM: IDLE --start_i&len!=0--> ISSUE --all len issued--> DRAIN --last word accepted--> IDLE (done_o=1 that cycle).
//    IDLE --start_i&len==0--> IDLE, done_o=1 next cycle, no ROM access. start_i while busy_o=1 ignored.
//  Issue: rom_cs_o=1 in ISSUE iff outstanding + fifo_count < FifoDepth (credit). Each issue: addr+=1, issued+=1.
//    Address wraps Depth-1 -> 0 (explicit compare; Depth need not be power of 2).
//    rom_cs_o is registered; rom_addr_o holds stable whenever rom_cs_o=0.
//  Return: ROM data valid the cycle after cs (rom_dvalid_i=1). Push rom_dout_i into FIFO iff rom_dvalid_i & outstanding!=0;
//    stray dvalid with outstanding=0 (e.g. first cycle after rst_i) is discarded.
//    outstanding is 0 or 1 (+1 on issue, -1 on push; both same cycle -> unchanged).
//  Stream: data_valid_o = FIFO non-empty; pop on valid&ready. data_o/data_last_o stable while valid&!ready.
//    last tag stored per entry: set on word whose returned-count == len.
//  Throughput: with data_ready_i held 1 and FifoDepth>=2, one word/cycle; first data_valid_o 2 cycles after start_i.
//  Simultaneous push+pop on full FIFO allowed; push into full FIFO impossible by credit rule (assert).
//  busy_o = (state!=IDLE); deasserts in the cycle done_o pulses.
//  Width rules: len_i is Aw+1 bits so len=Depth is legal; counters are Aw+1 bits.
// STRUCTURE
//  prim_rom_reader_pkg: state enum {IDLE, ISSUE, DRAIN}, localparam state width.
//  Sub-module prim_rom_reader_fifo: sync FIFO, Width+1 bits (data+last), FifoDepth entries, count out, sync reset.
//  Top: FSM, address/issue/return counters, credit logic. Target 150-250 lines total.
// TESTING (bench instantiates prim_generic_rom with known vmem, mem[i]=i^32'hA5A5_0000)
//  1 base=0x10,len=4,ready=1 -> data 0xA5A5_0010..0013 on 4 consecutive cycles, last on 4th, done_o 1 cycle later.
//  2 base=0x7FE,len=4,Depth=2048 -> addrs 0x7FE,0x7FF,0x000,0x001; data in that order; no X.
//  3 len=16, data_ready_i random 30% -> all 16 words in order, none dropped/duplicated; rom_cs_o never
//    asserted when outstanding+count==FifoDepth.
//  4 len=0 -> done_o pulse cycle after start, rom_cs_o never 1, data_valid_o stays 0; start while busy ignored.
//  5 rst_i mid-burst (after 3 words) -> all outputs 0 next cycle, stray ROM dvalid discarded; new burst base=0,len=2
//    returns exactly 0xA5A5_0000,0xA5A5_0001.
//  6 len=Depth -> Depth words, wraps to base, single last, single done_o.

Source files
------------

// File: rtl/prim_rom_reader_pkg.sv
// Shared constants for the ROM burst reader: FSM encoding and state width.
package prim_rom_reader_pkg;

  localparam int StateW = 2;

  localparam logic [StateW-1:0] StIdle  = 2'd0;
  localparam logic [StateW-1:0] StIssue = 2'd1;
  localparam logic [StateW-1:0] StDrain = 2'd2;

endpackage

// File: rtl/prim_rom_reader_fifo.sv
// Small synchronous FIFO holding {data, last} entries for the reader's output stream.
module prim_rom_reader_fifo #(
  parameter int Width = 33,
  parameter int Depth = 2,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
      if (pop_i)  rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/prim_rom_reader.sv
// Burst reader for a 1-cycle-latency synchronous ROM: fetches len words from base and streams them out.
// Stream handshake: a word transfers on a rising edge where data_valid_o & data_ready_i; while valid & !ready, data_o/data_last_o hold.
module prim_rom_reader
  import prim_rom_reader_pkg::*;
#(
  parameter int Width     = 32,
  parameter int Depth     = 2048,
  parameter int Aw        = $clog2(Depth),
  parameter int FifoDepth = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [Aw-1:0]     base_addr_i,
  input  logic [Aw:0]       len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [Aw-1:0]     rom_addr_o,
  output logic              rom_cs_o,
  input  logic [Width-1:0]  rom_dout_i,
  input  logic              rom_dvalid_i,
  output logic [Width-1:0]  data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              data_last_o,
  output logic [StateW-1:0] state_dbg_o
);

  localparam int Cw  = Aw + 1;
  localparam int FcW = $clog2(FifoDepth + 1);

  logic [StateW-1:0] state_q, state_d;
  logic [Aw-1:0]     addr_q, addr_d;
  logic              cs_q, cs_d;
  logic [Cw-1:0]     len_q, len_d, issued_q, issued_d, ret_q, ret_d;
  logic              outs_q, outs_d;
  logic              done_q, done_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FcW-1:0]    fifo_count;
  logic [Width:0]    fifo_rdata;
  logic              rom_push, rom_last, out_valid, out_last, out_pop;
  logic [Width-1:0]  out_data;
  logic [FcW:0]      cnt_next, credit_next;

  assign rom_push = rom_dvalid_i & outs_q;
  assign rom_last = ((ret_q + Cw'(1)) == len_q);

  // Returning ROM data bypasses an empty FIFO so one outstanding read plus an empty buffer sustains 1 word/cycle.
  assign out_valid = !fifo_empty | rom_push;
  assign {out_data, out_last} = fifo_empty ? {rom_dout_i, rom_last} : fifo_rdata;
  assign out_pop   = out_valid & data_ready_i;
  assign fifo_pop  = !fifo_empty & data_ready_i;
  assign fifo_push = rom_push & !(fifo_empty & data_ready_i);

  prim_rom_reader_fifo #(
    .Width (Width + 1),
    .Depth (FifoDepth),
    .CntW  (FcW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i ({rom_dout_i, rom_last}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    done_d   = 1'b0;
    outs_d   = cs_q | (outs_q & !rom_push);
    issued_d = issued_q + Cw'(cs_q);
    ret_d    = ret_q + Cw'(rom_push);
    addr_d   = addr_q;
    if (cs_q) addr_d = (addr_q == Aw'(Depth - 1)) ? '0 : addr_q + Aw'(1);

    case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d    = len_i;
          issued_d = '0;
          ret_d    = '0;
          addr_d   = base_addr_i;
          if (len_i != '0) state_d = StIssue;
          else             done_d  = 1'b1;
        end
      end
      StIssue: if (issued_d == len_q) state_d = StDrain;
      StDrain: begin
        if (out_pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Credit is taken on next-cycle occupancy, so the registered cs obeys outstanding + count < FifoDepth.
    cnt_next    = {1'b0, fifo_count} + (FcW + 1)'(fifo_push) - (FcW + 1)'(fifo_pop);
    credit_next = cnt_next + (FcW + 1)'(outs_d);
    cs_d        = (state_d == StIssue) && (credit_next < (FcW + 1)'(FifoDepth));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      len_q    <= '0;
      issued_q <= '0;
      ret_q    <= '0;
      outs_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      ret_q    <= ret_d;
      outs_q   <= outs_d;
      done_q   <= done_d;
    end
  end

  push_into_full_a: assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_push && fifo_full));

  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign rom_addr_o   = addr_q;
  assign rom_cs_o     = cs_q;
  assign data_valid_o = out_valid;
  assign data_o       = out_valid ? out_data : '0;
  assign data_last_o  = out_valid & out_last;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_prim_rom_reader.sv
// Bench for prim_rom_reader: behavioural ROM, stream scoreboard, table-driven bursts and corner sequences.
module tb_prim_rom_reader;

  localparam int DEPTH      = 2048;
  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [10:0] base_addr_i = '0;
  logic [11:0] len_i = '0;
  logic        busy_o, done_o, rom_cs_o, data_valid_o, data_last_o;
  logic [10:0] rom_addr_o;
  logic [31:0] data_o;
  logic        data_ready_i = 1'b1;
  logic [1:0]  state_dbg_o;
  logic [31:0] rom_dout = '0;
  logic        rom_dvalid = 1'b0;

  prim_rom_reader #(.Width(32), .Depth(DEPTH), .FifoDepth(FIFO_DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rom_addr_o   (rom_addr_o),
    .rom_cs_o     (rom_cs_o),
    .rom_dout_i   (rom_dout),
    .rom_dvalid_i (rom_dvalid),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_last_o  (data_last_o),
    .state_dbg_o  (state_dbg_o)
  );

  // Clock / reset-independent ROM model: mem[i] = i ^ 32'hA5A5_0000, one cycle latency.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_dvalid <= rom_cs_o;
    if (rom_cs_o) rom_dout <= {21'b0, rom_addr_o} ^ 32'hA5A5_0000;
  end

  int checks = 0, failures = 0;
  int issued = 0, accepted = 0, done_cnt = 0, valid_cnt = 0, cs_cnt = 0, burst_acc = 0;
  int ready_pct = 100;
  logic [31:0] first_data, last_data;
  logic [32:0] exp_q[$];
  logic [10:0] addr_log[$];

  typedef struct {
    string       name;
    int          base;
    int          len;
    int          rdy;
    logic [31:0] ef;
    logic [31:0] el;
    int          lat;
  } vec_t;
  vec_t vq[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    data_ready_i = ($urandom_range(0, 99) < ready_pct);
  end

  // Scoreboard: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_i) begin
      issued   = 0;
      accepted = 0;
    end else begin
      if (done_o) done_cnt++;
      if (data_valid_o) valid_cnt++;
      if (rom_cs_o) begin
        chk("credit", 64'(issued - accepted < FIFO_DEPTH), 1);
        addr_log.push_back(rom_addr_o);
        issued++;
        cs_cnt++;
      end
      if (data_valid_o && data_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", {data_last_o, data_o});
        end else begin
          chk("stream_word", {data_last_o, data_o}, exp_q.pop_front());
        end
        if (burst_acc == 0) first_data = data_o;
        last_data = data_o;
        burst_acc++;
        accepted++;
      end
    end
  end

  function automatic logic [31:0] model_word(int base, int k);
    int a = (base + k) % DEPTH;
    return 32'(a) ^ 32'hA5A5_0000;
  endfunction

  function automatic void load_exp(int base, int len);
    for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), model_word(base, k)});
  endfunction

  task automatic start_burst(input int base, input int len);
    @(posedge clk); #1;
    start_i = 1'b1;
    base_addr_i = 11'(base);
    len_i = 12'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit seen);
    n = 0;
    seen = 0;
    while (!seen && n <= budget) begin
      @(negedge clk);
      if (done_o) seen = 1;
      else n++;
    end
  endtask

  task automatic run_burst(input string name, input int base, input int len, input int rdy,
                           input logic [31:0] ef, input logic [31:0] el, input int lat);
    int n, d0, bad;
    bit seen;
    ready_pct = rdy;
    load_exp(base, len);
    addr_log.delete();
    burst_acc = 0;
    d0 = done_cnt;
    start_burst(base, len);
    wait_done(len * 30 + 50, n, seen);
    chk({name, "_done_seen"}, 64'(seen), 1);
    if (lat >= 0) chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_busy_at_done"}, 64'(busy_o), 0);
    @(negedge clk);
    chk({name, "_done_single"}, 64'(done_o), 0);
    chk({name, "_done_count"}, 64'(done_cnt - d0), 1);
    chk({name, "_words_left"}, 64'(exp_q.size()), 0);
    chk({name, "_first"}, 64'(first_data), 64'(ef));
    chk({name, "_last"}, 64'(last_data), 64'(el));
    bad = 0;
    for (int k = 0; k < addr_log.size(); k++)
      if (addr_log[k] !== 11'((base + k) % DEPTH)) bad++;
    chk({name, "_addr_count"}, 64'(addr_log.size()), 64'(len));
    chk({name, "_addr_seq"}, 64'(bad), 0);
    exp_q.delete();
  endtask

  initial begin
    int n, d0, v0, c0, b, l, r;
    bit seen;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_cs", 64'(rom_cs_o), 0);
    chk("rst_valid", 64'(data_valid_o), 0);
    chk("rst_last", 64'(data_last_o), 0);
    chk("rst_addr", 64'(rom_addr_o), 0);

    vq.push_back('{"basic",     'h10,  4, 100, 32'hA5A5_0010, 32'hA5A5_0013,  5});
    vq.push_back('{"wrap",      'h7FE, 4, 100, 32'hA5A5_07FE, 32'hA5A5_0001,  5});
    vq.push_back('{"bp16",      'h100, 16, 70, 32'hA5A5_0100, 32'hA5A5_010F, -1});
    vq.push_back('{"single",    'h7FF, 1, 100, 32'hA5A5_07FF, 32'hA5A5_07FF,  2});
    vq.push_back('{"long_full", 'h3F0, 32, 100, 32'hA5A5_03F0, 32'hA5A5_040F, 33});
    vq.push_back('{"slow",      'h000, 5,  30, 32'hA5A5_0000, 32'hA5A5_0004, -1});
    foreach (vq[i]) run_burst(vq[i].name, vq[i].base, vq[i].len, vq[i].rdy, vq[i].ef, vq[i].el, vq[i].lat);

    // len = 0: done next cycle, no ROM access, no stream activity.
    ready_pct = 100;
    d0 = done_cnt; v0 = valid_cnt; c0 = cs_cnt;
    start_burst('h55, 0);
    wait_done(20, n, seen);
    chk("len0_done_seen", 64'(seen), 1);
    chk("len0_latency", 64'(n), 0);
    chk("len0_busy", 64'(busy_o), 0);
    repeat (4) @(negedge clk);
    chk("len0_cs", 64'(cs_cnt - c0), 0);
    chk("len0_valid", 64'(valid_cnt - v0), 0);
    chk("len0_done_count", 64'(done_cnt - d0), 1);

    // start while busy is ignored.
    load_exp('h20, 4);
    d0 = done_cnt; c0 = cs_cnt;
    start_burst('h20, 4);
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = 11'h300; len_i = 12'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(100, n, seen);
    chk("busy_start_done_seen", 64'(seen), 1);
    v0 = valid_cnt;
    repeat (10) @(negedge clk);
    chk("busy_start_words_left", 64'(exp_q.size()), 0);
    chk("busy_start_no_extra", 64'(valid_cnt - v0), 0);
    chk("busy_start_cs_count", 64'(cs_cnt - c0), 4);
    chk("busy_start_done_count", 64'(done_cnt - d0), 1);

    // Reset mid-burst: outputs clear, stray ROM return discarded, next burst clean.
    load_exp('h40, 8);
    burst_acc = 0;
    d0 = done_cnt;
    start_burst('h40, 8);
    n = 0;
    while (burst_acc < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_progress", 64'(burst_acc >= 3), 1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy_o), 0);
    chk("rst_mid_done", 64'(done_o), 0);
    chk("rst_mid_cs", 64'(rom_cs_o), 0);
    chk("rst_mid_valid", 64'(data_valid_o), 0);
    chk("rst_mid_last", 64'(data_last_o), 0);
    chk("rst_mid_addr", 64'(rom_addr_o), 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 0);
    run_burst("post_rst", 0, 2, 100, 32'hA5A5_0000, 32'hA5A5_0001, 3);

    // Full-depth burst wrapping back to its base.
    run_burst("full_depth", 5, DEPTH, 100, 32'hA5A5_0005, 32'hA5A5_0004, DEPTH + 1);

    for (int i = 0; i < 6; i++) begin
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 40);
      r = $urandom_range(30, 100);
      run_burst($sformatf("rand%0d", i), b, l, r, model_word(b, 0), model_word(b, l - 1),
                (r == 100) ? l + 1 : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
